// File: rtl/bch_pkg.sv
// -----------------------------------------------------------------------------
// bch_pkg
// Shared definitions for the BCH encoder/decoder blocks over GF(2^13):
//   GF_M, GF_POLY : field degree and primitive polynomial x^13+x^4+x^3+x+1
//   bch_state_t   : encoder control states
//   GEN_T4        : 52-bit generator of the t=4 BCH(8191,8139) code, without
//                   the implicit x^52 term (bit i = coefficient of x^i)
// GEN_T4 is derived at elaboration time as m1*m3*m5*m7, the product of the
// minimal polynomials of alpha^1, alpha^3, alpha^5 and alpha^7. This avoids a
// hand-copied 52-bit magic number that could silently disagree with GF_POLY.
// -----------------------------------------------------------------------------
package bch_pkg;

   localparam int          GF_M    = 13;
   localparam logic [13:0] GF_POLY = 14'h201B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MSG  = 2'd1,
      PAR  = 2'd2
   } bch_state_t;

   // GF(2^13) multiply: shift-and-add, reducing by GF_POLY on each shift
   function automatic logic [12:0] gf_mul(input logic [12:0] a, input logic [12:0] b);
      logic [12:0] acc;
      logic [12:0] sh;
      acc = 13'd0;
      sh  = a;
      for (int i = 0; i < GF_M; i++) begin
         if (b[i]) acc = acc ^ sh;
         else      acc = acc;
         if (sh[12]) sh = {sh[11:0], 1'b0} ^ GF_POLY[12:0];
         else        sh = {sh[11:0], 1'b0};
      end
      return acc;
   endfunction

   // Minimal polynomial of alpha^e: product of (x + beta) over the 13
   // conjugates beta = alpha^(e*2^j). Its coefficients land in GF(2), so
   // only bit 0 of each field coefficient is kept.
   function automatic logic [13:0] gf_min_poly(input int e);
      logic [13:0][12:0] coef;
      logic [12:0]       root;
      logic [13:0]       res;
      coef    = '0;
      coef[0] = 13'd1;
      root    = 13'd1;
      for (int i = 0; i < e; i++) root = gf_mul(root, 13'd2);
      for (int j = 0; j < GF_M; j++) begin
         for (int k = 13; k > 0; k--) coef[k] = coef[k-1] ^ gf_mul(coef[k], root);
         coef[0] = gf_mul(coef[0], root);
         root    = gf_mul(root, root);
      end
      for (int k = 0; k < 14; k++) res[k] = coef[k][0];
      return res;
   endfunction

   // Generator for t=4: product of the four distinct minimal polynomials
   function automatic logic [51:0] bch_gen_t4();
      logic [52:0] g;
      logic [52:0] p;
      logic [13:0] m;
      g = 53'd1;
      for (int t = 0; t < 4; t++) begin
         m = gf_min_poly(2 * t + 1);
         p = 53'd0;
         for (int k = 0; k < 14; k++) begin
            if (m[k]) p = p ^ (g << k);
            else      p = p;
         end
         g = p;
      end
      return g[51:0];
   endfunction

   localparam logic [51:0] GEN_T4 = bch_gen_t4();

endpackage

// File: rtl/bch_lfsr_div.sv
// -----------------------------------------------------------------------------
// bch_lfsr_div
// R-bit Galois LFSR computing m(x)*x^R mod g(x), MSB first, plus a plain
// shift-out path used to unload the remainder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear of the parity register
//   shift_in_en  : absorb din into the remainder
//   shift_out_en : shift remainder left by one (parity unload)
//   din          : message bit
//   msb          : current parity register MSB (next parity bit out)
// clr has priority over both shift enables.
// -----------------------------------------------------------------------------
module bch_lfsr_div
   import bch_pkg::*;
#(
   parameter int           R   = 52,
   parameter logic [R-1:0] GEN = GEN_T4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic shift_in_en,
   input  logic shift_out_en,
   input  logic din,
   output logic msb
);

   logic [R-1:0] par_r;
   logic         fb_s;

   // Feedback: incoming bit plus the coefficient leaving the x^(R-1) position
   always_comb begin
      fb_s = din ^ par_r[R-1];
   end

   // Parity register: clear, divide step, or unload shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_r <= '0;
      end else if (clr) begin
         par_r <= '0;
      end else if (shift_in_en) begin
         par_r <= {par_r[R-2:0], 1'b0} ^ (fb_s ? GEN : {R{1'b0}});
      end else if (shift_out_en) begin
         par_r <= {par_r[R-2:0], 1'b0};
      end else begin
         par_r <= par_r;
      end
   end

   assign msb = par_r[R-1];

endmodule

// File: rtl/bch_serial_encoder.sv
// -----------------------------------------------------------------------------
// bch_serial_encoder
// Bit-serial systematic BCH encoder. Passes K message bits through (MSB first)
// then emits the R parity bits of m(x)*x^R mod g(x).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a codeword (honoured only in IDLE, not in a done cycle)
//   in_bit     : message bit, coefficient of x^(K-1) first
//   in_valid   : in_bit valid this cycle
//   in_ready   : encoder is in the message phase
//   out_bit    : registered codeword bit
//   out_valid  : out_bit valid
//   busy       : encoder not idle
//   done       : one-cycle pulse alongside the last parity bit
// -----------------------------------------------------------------------------
module bch_serial_encoder
   import bch_pkg::*;
#(
   parameter int           K   = 8139,
   parameter int           R   = 52,
   parameter logic [R-1:0] GEN = GEN_T4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic in_bit,
   input  logic in_valid,
   output logic in_ready,
   output logic out_bit,
   output logic out_valid,
   output logic busy,
   output logic done
);

   localparam int            CW      = $clog2(((K > R) ? K : R) + 1);
   localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
   localparam logic [CW-1:0] R_LAST  = CW'(R - 1);
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   bch_state_t    state_r;
   bch_state_t    state_nxt_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          out_bit_r;
   logic          out_bit_nxt_s;
   logic          out_valid_r;
   logic          out_valid_nxt_s;
   logic          done_r;
   logic          done_nxt_s;
   logic          in_ready_r;
   logic          busy_r;
   logic          clr_s;
   logic          shift_in_s;
   logic          shift_out_s;
   logic          par_msb_s;

   bch_lfsr_div #(
      .R   (R),
      .GEN (GEN)
   ) u_lfsr (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr_s),
      .shift_in_en  (shift_in_s),
      .shift_out_en (shift_out_s),
      .din          (in_bit),
      .msb          (par_msb_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, counter and output-bit selection
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      out_bit_nxt_s   = 1'b0;
      out_valid_nxt_s = 1'b0;
      done_nxt_s      = 1'b0;
      clr_s           = 1'b0;
      shift_in_s      = 1'b0;
      shift_out_s     = 1'b0;
      case (state_r)
         IDLE: begin
            // done_r high means the previous codeword finished this cycle;
            // a start seen then is dropped so the handshake has a gap.
            if (start && !done_r) begin
               clr_s       = 1'b1;
               cnt_nxt_s   = '0;
               state_nxt_s = MSG;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MSG: begin
            if (in_valid) begin
               shift_in_s      = 1'b1;
               out_bit_nxt_s   = in_bit;
               out_valid_nxt_s = 1'b1;
               if (cnt_r == K_LAST) begin
                  cnt_nxt_s   = '0;
                  state_nxt_s = PAR;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         PAR: begin
            shift_out_s     = 1'b1;
            out_bit_nxt_s   = par_msb_s;
            out_valid_nxt_s = 1'b1;
            if (cnt_r == R_LAST) begin
               done_nxt_s  = 1'b1;
               cnt_nxt_s   = '0;
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Counter and registered outputs; in_ready/busy follow the next state so
   // they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= '0;
         out_bit_r   <= 1'b0;
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         cnt_r       <= cnt_nxt_s;
         out_bit_r   <= out_bit_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         done_r      <= done_nxt_s;
         in_ready_r  <= (state_nxt_s == MSG);
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_bit   = out_bit_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_bch_serial_encoder.sv
module tb_bch_serial_encoder;
   import bch_pkg::*;

   localparam int          K_S     = 7;
   localparam int          R_S     = 8;
   localparam int          K_L     = 8139;
   localparam int          R_L     = 52;
   localparam logic [63:0] GEN_S64 = 64'h0000_0000_0000_00D1;

   logic clk = 1'b0;
   logic rst_n, start_s, start_l, in_bit, in_valid;
   logic s_in_ready, s_out_bit, s_out_valid, s_busy, s_done;
   logic l_in_ready, l_out_bit, l_out_valid, l_busy, l_done;

   always #5 clk = ~clk;

   bch_serial_encoder #(.K(K_S), .R(R_S), .GEN(8'hD1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(s_in_ready), .out_bit(s_out_bit), .out_valid(s_out_valid),
      .busy(s_busy), .done(s_done));

   bch_serial_encoder dut_l (
      .clk(clk), .rst_n(rst_n), .start(start_l), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(l_in_ready), .out_bit(l_out_bit), .out_valid(l_out_valid),
      .busy(l_busy), .done(l_done));

   int total = 0;
   int bad   = 0;
   bit msg_q[$];
   bit exp_q[$];
   bit work_q[$];
   bit res_q[$];
   bit q_s[$];
   bit q_l[$];
   int dcnt_s = 0, dpos_s = 0, dcnt_l = 0, dpos_l = 0;
   int res_done, res_done_idx;

   // Output collectors (only writers of q_*/dcnt_*/dpos_*)
   always @(negedge clk) begin
      if (s_out_valid === 1'b1) q_s.push_back(s_out_bit);
      if (s_done === 1'b1) begin
         dcnt_s <= dcnt_s + 1;
         dpos_s <= q_s.size();
      end
      if (l_out_valid === 1'b1) q_l.push_back(l_out_bit);
      if (l_done === 1'b1) begin
         dcnt_l <= dcnt_l + 1;
         dpos_l <= q_l.size();
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic rdy(input int sel);
      return sel != 0 ? l_in_ready : s_in_ready;
   endfunction

   function automatic logic dn(input int sel);
      return sel != 0 ? l_done : s_done;
   endfunction

   function automatic logic bsy(input int sel);
      return sel != 0 ? l_busy : s_busy;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) start_l = v;
      else          start_s = v;
   endtask

   function automatic logic [12:0] tb_gf_mul(input logic [12:0] a, input logic [12:0] b);
      logic [12:0] acc, sh;
      acc = 13'd0;
      sh  = a;
      for (int i = 0; i < 13; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[12] ? ({sh[11:0], 1'b0} ^ 13'h001B) : {sh[11:0], 1'b0};
      end
      return acc;
   endfunction

   // Polynomial long division over GF(2): work_q[0] is the highest coefficient
   task automatic reduce_work(input int r, input logic [63:0] gen);
      logic [63:0] gfull;
      gfull    = gen;
      gfull[r] = 1'b1;
      for (int i = 0; i + r < work_q.size(); i++) begin
         if (work_q[i]) begin
            for (int j = 0; j <= r; j++) work_q[i+j] = work_q[i+j] ^ gfull[r-j];
         end
      end
   endtask

   // Reference codeword: message followed by (m(x)*x^r mod g(x))
   task automatic build_expected(input int r, input logic [63:0] gen);
      work_q.delete();
      exp_q.delete();
      foreach (msg_q[i]) work_q.push_back(msg_q[i]);
      for (int i = 0; i < r; i++) work_q.push_back(1'b0);
      reduce_work(r, gen);
      foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
      for (int i = msg_q.size(); i < work_q.size(); i++) exp_q.push_back(work_q[i]);
   endtask

   // Remainder of res_q divided by g(x), folded to one bit (0 = divisible)
   task automatic res_remainder(input int r, input logic [63:0] gen, output bit nz);
      work_q.delete();
      foreach (res_q[i]) work_q.push_back(res_q[i]);
      reduce_work(r, gen);
      nz = 1'b0;
      for (int i = work_q.size() - r; i < work_q.size(); i++) nz = nz | work_q[i];
   endtask

   function automatic logic [14:0] pack_res();
      logic [14:0] v = 15'd0;
      foreach (res_q[i]) v = {v[13:0], res_q[i]};
      return v;
   endfunction

   function automatic logic [14:0] pack_exp();
      logic [14:0] v = 15'd0;
      foreach (exp_q[i]) v = {v[13:0], exp_q[i]};
      return v;
   endfunction

   task automatic load_msg7(input logic [6:0] m);
      msg_q.delete();
      for (int i = 6; i >= 0; i--) msg_q.push_back(m[i]);
   endtask

   task automatic load_rand(input int k);
      msg_q.delete();
      for (int i = 0; i < k; i++) msg_q.push_back(1'($urandom_range(1, 0)));
   endtask

   // Encode msg_q on one instance. Entered and left #1 after a rising edge;
   // on return the clock is one cycle past the done cycle. poke adds start
   // pulses mid-message, mid-parity and in the done cycle, plus in_valid noise
   // during parity.
   task automatic encode(input int sel, input int max_gap, input bit poke);
      int bq, bd, cyc, gap, r;
      bit seen;
      r  = (sel != 0) ? R_L : R_S;
      bq = (sel != 0) ? q_l.size() : q_s.size();
      bd = (sel != 0) ? dcnt_l : dcnt_s;
      in_valid = 1'b0;
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      for (int i = 0; i < msg_q.size(); i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_bit   = msg_q[i];
         if (poke && i == msg_q.size() / 2) set_start(sel, 1'b1);
         cyc = 0;
         while (rdy(sel) !== 1'b1 && cyc < 16) begin
            @(posedge clk); #1;
            cyc++;
         end
         if (cyc >= 16) begin
            total++; bad++;
            $display("FAIL in_ready_timeout: bit %0d, in_ready=%b required 1", i, rdy(sel));
         end
         @(posedge clk); #1;
         set_start(sel, 1'b0);
      end
      in_valid = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < r + 8) begin
         if (poke) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(1, 0));
            set_start(sel, (cyc == 2) ? 1'b1 : 1'b0);
         end
         @(posedge clk); #1;
         cyc++;
         seen = (dn(sel) === 1'b1);
      end
      in_valid = 1'b0;
      if (!seen) begin
         total++; bad++;
         $display("FAIL done_timeout: done=%b required 1 within %0d cycles", dn(sel), r + 8);
      end
      set_start(sel, poke ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      res_q.delete();
      if (sel != 0) begin
         for (int i = bq; i < q_l.size(); i++) res_q.push_back(q_l[i]);
         res_done     = dcnt_l - bd;
         res_done_idx = dpos_l - bq;
      end else begin
         for (int i = bq; i < q_s.size(); i++) res_q.push_back(q_s[i]);
         res_done     = dcnt_s - bd;
         res_done_idx = dpos_s - bq;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_s = 1'b0; start_l = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({s_out_bit, s_out_valid, s_in_ready, s_busy, s_done} !== 5'b0) begin
         bad++;
         $display("FAIL reset_small: outputs=%b required 00000",
                  {s_out_bit, s_out_valid, s_in_ready, s_busy, s_done});
      end
      total++;
      if ({l_out_bit, l_out_valid, l_in_ready, l_busy, l_done} !== 5'b0) begin
         bad++;
         $display("FAIL reset_large: outputs=%b required 00000",
                  {l_out_bit, l_out_valid, l_in_ready, l_busy, l_done});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({s_busy, s_out_valid, l_busy, l_out_valid} !== 4'b0) begin
         bad++;
         $display("FAIL idle_after_reset: busy/valid=%b required 0000",
                  {s_busy, s_out_valid, l_busy, l_out_valid});
      end
   endtask

   task automatic test_known_vector();
      logic [14:0] want;
      want = 15'b000000111010001;
      load_msg7(7'b0000001);
      encode(0, 0, 1'b0);
      total++;
      if (res_q.size() != 15) begin
         bad++;
         $display("FAIL known_count: out_valid bits=%0d required 15", res_q.size());
      end
      total++;
      if (pack_res() !== want) begin
         bad++;
         $display("FAIL known_codeword: got %b required %b", pack_res(), want);
      end
      total++;
      if (res_done != 1 || res_done_idx != 15) begin
         bad++;
         $display("FAIL known_done: pulses=%0d at bit %0d required 1 at 15", res_done, res_done_idx);
      end
   endtask

   task automatic test_all_zero();
      load_msg7(7'b0000000);
      encode(0, 3, 1'b0);
      total++;
      if (res_q.size() != 15 || pack_res() !== 15'd0) begin
         bad++;
         $display("FAIL zero_codeword: %0d bits %b required 15 bits 0", res_q.size(), pack_res());
      end
      total++;
      if (res_done != 1 || res_done_idx != 15) begin
         bad++;
         $display("FAIL zero_done: pulses=%0d at bit %0d required 1 at 15", res_done, res_done_idx);
      end
      total++;
      if (s_busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_busy_after_done: busy=%b required 0", s_busy);
      end
   endtask

   task automatic test_linearity();
      logic [6:0]  ma, mb;
      logic [14:0] cw [3];
      bit          nz;
      ma = 7'b1010011;
      mb = 7'b0110101;
      for (int t = 0; t < 3; t++) begin
         load_msg7(t == 0 ? ma : (t == 1 ? mb : (ma ^ mb)));
         encode(0, 2, 1'b0);
         @(posedge clk); #1;
         build_expected(R_S, GEN_S64);
         cw[t] = pack_res();
         total++;
         if (res_q.size() != 15 || cw[t] !== pack_exp()) begin
            bad++;
            $display("FAIL lin_codeword_%0d: got %b required %b", t, cw[t], pack_exp());
         end
         res_remainder(R_S, GEN_S64, nz);
         total++;
         if (nz !== 1'b0) begin
            bad++;
            $display("FAIL lin_divisible_%0d: remainder nonzero for %b, required 0", t, cw[t]);
         end
      end
      total++;
      if (cw[2][7:0] !== (cw[0][7:0] ^ cw[1][7:0])) begin
         bad++;
         $display("FAIL lin_parity_xor: got %b required %b", cw[2][7:0], cw[0][7:0] ^ cw[1][7:0]);
      end
   endtask

   task automatic test_start_ignored();
      load_rand(K_S);
      msg_q[0] = 1'b1;
      build_expected(R_S, GEN_S64);
      @(posedge clk); #1;
      encode(0, 2, 1'b1);
      total++;
      if (res_q.size() != 15 || pack_res() !== pack_exp()) begin
         bad++;
         $display("FAIL poke_codeword: got %b required %b", pack_res(), pack_exp());
      end
      total++;
      if (res_done != 1 || res_done_idx != 15) begin
         bad++;
         $display("FAIL poke_done: pulses=%0d at bit %0d required 1 at 15", res_done, res_done_idx);
      end
      total++;
      if (s_busy !== 1'b0) begin
         bad++;
         $display("FAIL poke_start_on_done: busy=%b required 0", s_busy);
      end
   endtask

   task automatic test_reset_mid();
      int bq;
      @(posedge clk); #1;
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s  = 1'b0;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({s_out_bit, s_out_valid, s_in_ready, s_busy, s_done} !== 5'b0) begin
         bad++;
         $display("FAIL reset_mid_outputs: outputs=%b required 00000",
                  {s_out_bit, s_out_valid, s_in_ready, s_busy, s_done});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bq = q_s.size();
      repeat (5) begin
         @(posedge clk); #1;
      end
      total++;
      if (q_s.size() != bq || s_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_quiet: extra bits=%0d busy=%b required 0 and 0", q_s.size() - bq, s_busy);
      end
      load_rand(K_S);
      build_expected(R_S, GEN_S64);
      encode(0, 1, 1'b0);
      total++;
      if (res_q.size() != 15 || pack_res() !== pack_exp()) begin
         bad++;
         $display("FAIL reset_mid_fresh: got %b required %b", pack_res(), pack_exp());
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      for (int t = 0; t < 4; t++) begin
         load_rand(K_S);
         if (t == 0) msg_q[K_S-1] = 1'b1;
         build_expected(R_S, GEN_S64);
         encode(0, (t == 3) ? 0 : 2, 1'b0);
         total++;
         if (res_q.size() != 15 || pack_res() !== pack_exp() || res_done_idx != 15) begin
            bad++;
            $display("FAIL b2b_codeword_%0d: got %b (%0d bits, done at %0d) required %b",
                     t, pack_res(), res_q.size(), res_done_idx, pack_exp());
         end
      end
   endtask

   task automatic test_default_random();
      int          nerr_msg, nerr_cw;
      logic [12:0] beta, syn;
      load_rand(K_L);
      build_expected(R_L, 64'(GEN_T4));
      @(posedge clk); #1;
      encode(1, 5, 1'b0);
      total++;
      if (res_q.size() != K_L + R_L) begin
         bad++;
         $display("FAIL big_count: out_valid bits=%0d required %0d", res_q.size(), K_L + R_L);
      end
      nerr_msg = 0;
      nerr_cw  = 0;
      for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
         if (res_q[i] !== exp_q[i]) begin
            nerr_cw++;
            if (i < K_L) nerr_msg++;
         end
      end
      total++;
      if (nerr_msg != 0) begin
         bad++;
         $display("FAIL big_message_passthrough: %0d bits differ, required 0", nerr_msg);
      end
      total++;
      if (nerr_cw != 0) begin
         bad++;
         $display("FAIL big_codeword: %0d bits differ from model, required 0", nerr_cw);
      end
      total++;
      if (res_done != 1 || res_done_idx != K_L + R_L) begin
         bad++;
         $display("FAIL big_done: pulses=%0d at bit %0d required 1 at %0d", res_done, res_done_idx, K_L + R_L);
      end
      // Roots alpha^1..alpha^8 of g(x) must all be roots of the codeword
      beta = 13'd1;
      for (int j = 1; j <= 8; j++) begin
         beta = tb_gf_mul(beta, 13'd2);
         syn  = 13'd0;
         foreach (res_q[i]) syn = tb_gf_mul(syn, beta) ^ {12'd0, res_q[i]};
         total++;
         if (syn !== 13'd0) begin
            bad++;
            $display("FAIL big_syndrome_S%0d: got %h required 0", j, syn);
         end
      end
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_all_zero();
      test_linearity();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_default_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bch_serial_encoder.md
Name: bch_serial_encoder

Overview:
Bit-serial systematic BCH encoder: the transmit-side counterpart of the decoder datapath that uses the GF(2^13) inverse block. It accepts K message bits MSB-first and emits the N = K+R bit codeword, also MSB-first: first the K message bits unchanged, then the R parity bits. Parity is the remainder of m(x)·x^R divided by g(x), computed with an R-bit LFSR. It uses the same start/done handshake as the other GF blocks in the codebase.

Parameters:
K, 8139, message length in bits (default is the t=4 code over GF(2^13): N=8191)
R, 52, parity length in bits, equal to deg g(x)
GEN, bch_pkg::GEN_T4, R-bit generator polynomial without the implicit x^R term; bit i is the coefficient of x^i

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a codeword; sampled only in IDLE
in_bit  in  1  message bit, MSB (coefficient of x^(K-1)) first
in_valid  in  1  in_bit is valid this cycle
in_ready  out  1  encoder accepts a message bit this cycle
out_bit  out  1  codeword bit, registered
out_valid  out  1  out_bit is valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, asserted in the same cycle as the last parity bit

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; parity register = 0; bit counter = 0.
  - out_bit, out_valid, in_ready, busy and done all 0.
  - Reset asserted mid-codeword aborts it. No partial output follows the release of reset.
- IDLE:
  - in_ready=0.
  - start=1 → clear the parity register and counter, go to MSG. The first message bit can be accepted in the next cycle.
- MSG:
  - in_ready=1.
  - On each in_valid=1 cycle:
    - fb = in_bit ^ par[R-1]
    - par <= {par[R-2:0],1'b0} ^ (fb ? GEN : 0)
    - out_bit <= in_bit; out_valid <= 1; counter increments.
  - in_valid=0 → no shift, no count, out_valid <= 0 (stall, unbounded).
  - When the K-th bit is accepted: counter resets to 0, go to PAR.
- PAR:
  - in_ready=0; in_valid is ignored.
  - Each cycle: out_bit <= par[R-1]; par <= par<<1; out_valid <= 1. There are no stalls.
  - After R cycles: done=1 in the same cycle out_valid presents the final parity bit. Go to IDLE.
- Latency:
  - Each message bit appears on out_bit one cycle after it is accepted.
  - The first parity bit immediately follows the last message bit on out_bit.
  - The total is exactly K+R out_valid cycles per codeword.
- start while busy is ignored. start in the same cycle that done is high is also ignored. start is honoured from the cycle after done.
- Counter width: $clog2(max(K,R)+1). Counting is exact; there is no wrap-around beyond K or R.
- The output is a pure function of the message. The encoder has no carry-over between codewords.

Decomposition:
- Package bch_pkg holds:
  - GF_M=13 and the field primitive polynomial constant.
  - GEN_T4 (52-bit generator for t=4).
  - The state enum {IDLE, MSG, PAR}.
- One sub-module, bch_lfsr_div (parameters R, GEN). Inputs: clr, shift_in_en, shift_out_en, din. Output: msb. It holds the parity register and the feedback XOR network.
- The FSM, counter and output registers stay in the top level.

Test Plan:
- Override K=7, R=8, GEN=8'hD1 (g=x^8+x^7+x^6+x^4+1, BCH(15,7)); message 0000001 → out 000000111010001, done on the 15th out_valid.
- Same code, all-zero message → 15 zero bits out, done=1 with the last bit, busy=0 the next cycle.
- Same code, messages A=1010011 and B=0110101 encoded separately, then A^B → parity(A^B) = parity(A)^parity(B); every codeword is divisible by g(x) in the bench model.
- Default parameters, random 8139-bit message with random in_valid gaps of 0–5 cycles → exactly 8191 out_valid bits; the first 8139 equal the input; the codeword matches the software model.
- start pulsed mid-MSG and mid-PAR → ignored, output unchanged; rst_n pulsed low mid-MSG → all outputs 0 immediately, then a fresh codeword after start encodes correctly.
- Back-to-back: start asserted the cycle after done → the second codeword is correct, with no leftover parity from the first.
